// File: rtl/vmecpld_pkg.sv
// Shared constants and state encoding for the VME A16/D8 register controller.
package vmecpld_pkg;

  localparam logic [5:0] AM_A16_USER = 6'h29;
  localparam logic [5:0] AM_A16_SUPV = 6'h2D;

  localparam logic [1:0] REG_CSR   = 2'd0;
  localparam logic [1:0] REG_FDATA = 2'd1;
  localparam logic [1:0] REG_FCS   = 2'd2;
  localparam logic [1:0] REG_ID    = 2'd3;

  localparam logic [7:0] ID_VALUE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    WAIT_DS,
    ACCESS,
    ACK,
    RELEASE,
    WAIT_AS
  } state_t;

  function automatic logic am_ok(input logic [5:0] am);
    return (am == AM_A16_USER) || (am == AM_A16_SUPV);
  endfunction

endpackage

// File: rtl/vme_a16_regctl_if.sv
// VME A16/D8 slave-side bus bundle; the master modport is the bus/backplane side.
interface vme_a16_regctl_if;

  logic [15:0] XA;
  logic [5:0]  XAM;
  logic [5:0]  XGA;
  logic        XAS;
  logic [1:0]  XDS;
  logic        XWRITE;
  logic        XIACK;
  logic [7:0]  XDI;
  logic [7:0]  XDO;
  logic        XDOE;
  logic        DDIR;
  logic        XDTACK;
  logic        XDTACKOE;

  modport master (
    output XA, XAM, XGA, XAS, XDS, XWRITE, XIACK, XDI,
    input  XDO, XDOE, DDIR, XDTACK, XDTACKOE
  );

  modport slave (
    input  XA, XAM, XGA, XAS, XDS, XWRITE, XIACK, XDI,
    output XDO, XDOE, DDIR, XDTACK, XDTACKOE
  );

endinterface

// File: rtl/spi_byte_shifter.sv
// Byte-wide SPI mode 0 master, MSB first; SCK half-period is SPI_HALF CPLDCLK cycles.
module spi_byte_shifter #(
  parameter int SPI_HALF = 2
) (
  input  logic       CPLDCLK,
  input  logic       XRESET,
  input  logic       start,
  input  logic [7:0] din,
  input  logic       FMISO,
  output logic       busy,
  output logic [7:0] dout,
  output logic       FSCK,
  output logic       FMOSI
);

  localparam logic [7:0] DIV_LAST = 8'(SPI_HALF - 1);

  logic [7:0] txsh;
  logic [7:0] rxsh;
  logic [7:0] div;
  logic [3:0] nbits;
  logic       fin;

  // fin marks the 8th falling SCK; busy drops and dout updates one edge later
  always_ff @(posedge CPLDCLK or negedge XRESET) begin
    if (!XRESET) begin
      busy  <= 1'b0;
      dout  <= 8'h00;
      FSCK  <= 1'b0;
      FMOSI <= 1'b0;
      txsh  <= 8'h00;
      rxsh  <= 8'h00;
      div   <= 8'h00;
      nbits <= 4'd0;
      fin   <= 1'b0;
    end else if (fin) begin
      busy <= 1'b0;
      fin  <= 1'b0;
      dout <= rxsh;
    end else if (!busy) begin
      if (start) begin
        busy  <= 1'b1;
        txsh  <= din;
        FMOSI <= din[7];
        div   <= 8'h00;
        nbits <= 4'd0;
      end
    end else if (div != DIV_LAST) begin
      div <= div + 8'd1;
    end else begin
      div <= 8'h00;
      if (!FSCK) begin
        FSCK <= 1'b1;
        rxsh <= {rxsh[6:0], FMISO};
      end else begin
        FSCK  <= 1'b0;
        txsh  <= {txsh[6:0], 1'b0};
        FMOSI <= txsh[6];
        nbits <= nbits + 4'd1;
        if (nbits == 4'd7) fin <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/vme_a16_regctl.sv
// VME A16/D8 slave controller: strobe sync, geographic decode, DTACK sequencing, CSR/SPI regs.
// Define VMECPLD_GAPAR_EN to require odd parity over XGA[5:0].
module vme_a16_regctl
  import vmecpld_pkg::*;
#(
  parameter logic [2:0] BASE_PREFIX = 3'b000,
  parameter int         SPI_HALF    = 2
) (
  input  logic             CPLDCLK,
  input  logic             XRESET,
  vme_a16_regctl_if.slave  vme,
  output logic             PROG_N,
  output logic [1:0]       M,
  input  logic             DONE,
  input  logic             INIT,
  output logic             FCS_N,
  output logic             FSCK,
  output logic             FMOSI,
  input  logic             FMISO
);

  logic [1:0] as_sr, ds_sr, wr_sr, iack_sr;
  logic       as_s, ds_s, wr_s, iack_s;
  logic       parity_ok, addr_match;
  logic [7:0] rdata;
  logic [1:0] sel;
  logic       rd_cyc, stall;
  logic       spi_start, spi_busy;
  logic [7:0] spi_tx, spi_rx;
  logic       unused_bits;
  state_t     state;

  assign as_s   = as_sr[1];
  assign ds_s   = ds_sr[1];
  assign wr_s   = wr_sr[1];
  assign iack_s = iack_sr[1];
  assign unused_bits = ^{vme.XDS[1], vme.XGA[5]};

`ifdef VMECPLD_GAPAR_EN
  assign parity_ok = ^vme.XGA;
`else
  assign parity_ok = 1'b1;
`endif

  // XGA is active-low, so the slot number is its complement
  always_comb begin
    addr_match = !as_s && am_ok(vme.XAM) && iack_s && parity_ok &&
                 (vme.XA[15:13] == BASE_PREFIX) &&
                 (vme.XA[12:8] == ~vme.XGA[4:0]) &&
                 (vme.XA[7:2] == 6'd0);
  end

  always_comb begin
    unique case (sel)
      REG_CSR:   rdata = {DONE, INIT, 2'b00, M, 1'b0, PROG_N};
      REG_FDATA: rdata = spi_rx;
      REG_FCS:   rdata = {7'd0, FCS_N};
      default:   rdata = ID_VALUE;
    endcase
  end

  always_ff @(posedge CPLDCLK or negedge XRESET) begin
    if (!XRESET) begin
      as_sr   <= 2'b11;
      ds_sr   <= 2'b11;
      wr_sr   <= 2'b11;
      iack_sr <= 2'b11;
    end else begin
      as_sr   <= {as_sr[0], vme.XAS};
      ds_sr   <= {ds_sr[0], vme.XDS[0]};
      wr_sr   <= {wr_sr[0], vme.XWRITE};
      iack_sr <= {iack_sr[0], vme.XIACK};
    end
  end

  // Read data is latched on entry to ACCESS so XDO settles a cycle before DTACK;
  // a stalled FDATA read re-latches once the shifter goes idle, costing one more cycle.
  always_ff @(posedge CPLDCLK or negedge XRESET) begin
    if (!XRESET) begin
      state        <= IDLE;
      vme.XDTACK   <= 1'b1;
      vme.XDTACKOE <= 1'b1;
      vme.XDOE     <= 1'b0;
      vme.DDIR     <= 1'b0;
      vme.XDO      <= 8'h00;
      PROG_N       <= 1'b1;
      M            <= 2'b11;
      FCS_N        <= 1'b1;
      sel          <= 2'd0;
      rd_cyc       <= 1'b0;
      stall        <= 1'b0;
      spi_start    <= 1'b0;
      spi_tx       <= 8'h00;
    end else begin
      spi_start <= 1'b0;
      unique case (state)
        IDLE: if (!as_s) state <= DECODE;
        DECODE: begin
          sel    <= vme.XA[1:0];
          rd_cyc <= wr_s;
          state  <= addr_match ? WAIT_DS : WAIT_AS;
        end
        WAIT_DS: begin
          if (as_s) begin
            state <= IDLE;
          end else if (!ds_s) begin
            state <= ACCESS;
            stall <= 1'b0;
            if (rd_cyc) begin
              vme.XDO  <= rdata;
              vme.XDOE <= 1'b1;
              vme.DDIR <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (sel == REG_FDATA && spi_busy) begin
            stall <= 1'b1;
          end else if (stall && rd_cyc) begin
            vme.XDO <= rdata;
            stall   <= 1'b0;
          end else begin
            if (!rd_cyc) begin
              unique case (sel)
                REG_CSR: begin
                  PROG_N <= vme.XDI[0];
                  M      <= vme.XDI[3:2];
                end
                REG_FDATA: begin
                  spi_start <= 1'b1;
                  spi_tx    <= vme.XDI;
                end
                REG_FCS: FCS_N <= vme.XDI[0];
                default: ;
              endcase
            end
            state        <= ACK;
            vme.XDTACK   <= 1'b0;
            vme.XDTACKOE <= 1'b0;
          end
        end
        ACK: begin
          if (ds_s) begin
            state      <= RELEASE;
            vme.XDTACK <= 1'b1;
            vme.XDOE   <= 1'b0;
            vme.DDIR   <= 1'b0;
          end
        end
        RELEASE: begin
          state        <= WAIT_AS;
          vme.XDTACKOE <= 1'b1;
        end
        WAIT_AS: if (as_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  spi_byte_shifter #(.SPI_HALF(SPI_HALF)) u_spi (
    .CPLDCLK (CPLDCLK),
    .XRESET  (XRESET),
    .start   (spi_start),
    .din     (spi_tx),
    .FMISO   (FMISO),
    .busy    (spi_busy),
    .dout    (spi_rx),
    .FSCK    (FSCK),
    .FMOSI   (FMOSI)
  );

endmodule

// File: tb/tb_vme_a16_regctl.sv
// Directed bench for vme_a16_regctl: handshake timing, register access, SPI loopback, decode misses.
module tb_vme_a16_regctl;

  localparam logic [5:0] GA_SLOT16 = 6'b101111;

  logic       CPLDCLK = 1'b0;
  logic       XRESET;
  logic       PROG_N;
  logic [1:0] M;
  logic       DONE, INIT;
  logic       FCS_N, FSCK, FMOSI, FMISO;

  int tests = 0;
  int failures = 0;
  int cyc = 0;
  int sckCount = 0;
  logic [7:0] mosiByte = 8'h00;

  vme_a16_regctl_if vme ();

  vme_a16_regctl #(.BASE_PREFIX(3'b000), .SPI_HALF(2)) dut (
    .CPLDCLK (CPLDCLK),
    .XRESET  (XRESET),
    .vme     (vme),
    .PROG_N  (PROG_N),
    .M       (M),
    .DONE    (DONE),
    .INIT    (INIT),
    .FCS_N   (FCS_N),
    .FSCK    (FSCK),
    .FMOSI   (FMOSI),
    .FMISO   (FMISO)
  );

  assign FMISO = FMOSI;

  always #5 CPLDCLK = ~CPLDCLK;

  always @(posedge CPLDCLK) cyc <= cyc + 1;

  // Mode 0: the bit on FMOSI is valid at each rising FSCK
  always @(posedge FSCK) begin
    mosiByte <= {mosiByte[6:0], FMOSI};
    sckCount <= sckCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [5:0] am, input logic [5:0] ga,
                               input bit wr, input logic [7:0] d, input bit iack);
    @(negedge CPLDCLK);
    vme.XA     = a;
    vme.XAM    = am;
    vme.XGA    = ga;
    vme.XWRITE = !wr;
    vme.XIACK  = !iack;
    vme.XDI    = d;
    @(negedge CPLDCLK);
    vme.XAS = 1'b0;
    @(negedge CPLDCLK);
    @(negedge CPLDCLK);
    vme.XDS = 2'b00;
  endtask

  task automatic waitAck(input int maxc, output int cnt, output bit acked, output bit oeLow);
    cnt = 0;
    acked = 1'b0;
    oeLow = 1'b0;
    while (cnt < maxc && !acked) begin
      @(posedge CPLDCLK);
      cnt++;
      @(negedge CPLDCLK);
      if (vme.XDTACKOE !== 1'b1) oeLow = 1'b1;
      if (vme.XDTACK === 1'b0) acked = 1'b1;
    end
  endtask

  task automatic endBus();
    vme.XDS = 2'b11;
    vme.XAS = 1'b1;
    repeat (4) @(negedge CPLDCLK);
  endtask

  task automatic busCycle(input logic [15:0] a, input bit wr, input logic [7:0] d,
                          output int ackCnt, output int ackCyc, output int relCnt,
                          output logic [7:0] rd, output logic ddir, output logic doe,
                          output logic oeStill, output logic oeBack);
    bit acked, oeLow;
    applyStimulus(a, 6'h2D, GA_SLOT16, wr, d, 1'b0);
    waitAck(200, ackCnt, acked, oeLow);
    ackCyc = cyc;
    rd   = vme.XDO;
    ddir = vme.DDIR;
    doe  = vme.XDOE;
    vme.XDS = 2'b11;
    relCnt = 0;
    while (relCnt < 20 && vme.XDTACK !== 1'b1) begin
      @(posedge CPLDCLK);
      relCnt++;
      @(negedge CPLDCLK);
    end
    oeStill = vme.XDTACKOE;
    @(posedge CPLDCLK);
    @(negedge CPLDCLK);
    oeBack = vme.XDTACKOE;
    endBus();
  endtask

  task automatic missCycle(input string tag, input logic [15:0] a, input logic [5:0] am, input bit iack);
    int cnt;
    bit acked, oeLow;
    applyStimulus(a, am, GA_SLOT16, 1'b1, 8'h55, iack);
    waitAck(20, cnt, acked, oeLow);
    checkOutput({tag, "_noack"}, 32'(acked), 32'd0);
    checkOutput({tag, "_oe_high"}, 32'(oeLow), 32'd0);
    endBus();
  endtask

  initial begin
    int ackCnt, ackCyc, relCnt, ackCyc1, s0;
    logic [7:0] rd;
    logic ddir, doe, oeStill, oeBack;
    bit acked, oeLow;

    vme.XA = 16'h0; vme.XAM = 6'h0; vme.XGA = 6'h3F; vme.XAS = 1'b1;
    vme.XDS = 2'b11; vme.XWRITE = 1'b1; vme.XIACK = 1'b1; vme.XDI = 8'h0;
    DONE = 1'b1; INIT = 1'b1;
    XRESET = 1'b1;
    #3 XRESET = 1'b0;
    #3;
    checkOutput("rst_dtack", 32'(vme.XDTACK), 32'd1);
    checkOutput("rst_dtackoe", 32'(vme.XDTACKOE), 32'd1);
    checkOutput("rst_xdoe", 32'(vme.XDOE), 32'd0);
    checkOutput("rst_ddir", 32'(vme.DDIR), 32'd0);
    checkOutput("rst_xdo", 32'(vme.XDO), 32'd0);
    checkOutput("rst_prog_n", 32'(PROG_N), 32'd1);
    checkOutput("rst_m", 32'(M), 32'd3);
    checkOutput("rst_fcs_n", 32'(FCS_N), 32'd1);
    checkOutput("rst_fsck", 32'(FSCK), 32'd0);
    checkOutput("rst_fmosi", 32'(FMOSI), 32'd0);
    repeat (3) @(negedge CPLDCLK);
    XRESET = 1'b1;
    repeat (2) @(negedge CPLDCLK);

    busCycle(16'h1000, 1'b1, 8'h01, ackCnt, ackCyc, relCnt, rd, ddir, doe, oeStill, oeBack);
    checkOutput("csr_wr_ack_lat", 32'(ackCnt), 32'd4);
    checkOutput("csr_wr_rel_lat", 32'(relCnt), 32'd3);
    checkOutput("csr_wr_oe_release", 32'(oeStill), 32'd0);
    checkOutput("csr_wr_oe_back", 32'(oeBack), 32'd1);
    checkOutput("csr_wr_prog_n", 32'(PROG_N), 32'd1);
    checkOutput("csr_wr_m", 32'(M), 32'd0);

    busCycle(16'h1000, 1'b1, 8'h0D, ackCnt, ackCyc, relCnt, rd, ddir, doe, oeStill, oeBack);
    busCycle(16'h1000, 1'b0, 8'h00, ackCnt, ackCyc, relCnt, rd, ddir, doe, oeStill, oeBack);
    checkOutput("csr_rd_ack_lat", 32'(ackCnt), 32'd4);
    checkOutput("csr_rd_data", 32'(rd), 32'hCD);
    checkOutput("csr_rd_ddir_ack", 32'(ddir), 32'd1);
    checkOutput("csr_rd_xdoe_ack", 32'(doe), 32'd1);
    checkOutput("csr_rd_ddir_after", 32'(vme.DDIR), 32'd0);
    checkOutput("csr_rd_xdoe_after", 32'(vme.XDOE), 32'd0);

    busCycle(16'h1003, 1'b0, 8'h00, ackCnt, ackCyc, relCnt, rd, ddir, doe, oeStill, oeBack);
    checkOutput("id_rd", 32'(rd), 32'hA5);
    busCycle(16'h1003, 1'b1, 8'h00, ackCnt, ackCyc, relCnt, rd, ddir, doe, oeStill, oeBack);
    checkOutput("id_wr_ack_lat", 32'(ackCnt), 32'd4);
    busCycle(16'h1003, 1'b0, 8'h00, ackCnt, ackCyc, relCnt, rd, ddir, doe, oeStill, oeBack);
    checkOutput("id_rd_after_wr", 32'(rd), 32'hA5);

    busCycle(16'h1002, 1'b1, 8'h00, ackCnt, ackCyc, relCnt, rd, ddir, doe, oeStill, oeBack);
    checkOutput("fcs_wr_pin", 32'(FCS_N), 32'd0);
    busCycle(16'h1002, 1'b0, 8'h00, ackCnt, ackCyc, relCnt, rd, ddir, doe, oeStill, oeBack);
    checkOutput("fcs_rd", 32'(rd), 32'h00);

    s0 = sckCount;
    busCycle(16'h1001, 1'b1, 8'h9A, ackCnt, ackCyc, relCnt, rd, ddir, doe, oeStill, oeBack);
    checkOutput("fdata_wr_ack_lat", 32'(ackCnt), 32'd4);
    repeat (60) @(negedge CPLDCLK);
    checkOutput("fdata_sck_pulses", 32'(sckCount - s0), 32'd8);
    checkOutput("fdata_mosi_byte", 32'(mosiByte), 32'h9A);
    busCycle(16'h1001, 1'b0, 8'h00, ackCnt, ackCyc, relCnt, rd, ddir, doe, oeStill, oeBack);
    checkOutput("fdata_rd", 32'(rd), 32'h9A);

    s0 = sckCount;
    busCycle(16'h1001, 1'b1, 8'h3C, ackCnt, ackCyc1, relCnt, rd, ddir, doe, oeStill, oeBack);
    busCycle(16'h1001, 1'b1, 8'h5A, ackCnt, ackCyc, relCnt, rd, ddir, doe, oeStill, oeBack);
    checkOutput("b2b_wr_stalled", 32'(ackCnt > 4), 32'd1);
    checkOutput("b2b_wr_gap", 32'((ackCyc - ackCyc1) >= 32), 32'd1);
    repeat (60) @(negedge CPLDCLK);
    checkOutput("b2b_sck_pulses", 32'(sckCount - s0), 32'd16);
    checkOutput("b2b_mosi_byte", 32'(mosiByte), 32'h5A);
    busCycle(16'h1001, 1'b0, 8'h00, ackCnt, ackCyc, relCnt, rd, ddir, doe, oeStill, oeBack);
    checkOutput("b2b_rd", 32'(rd), 32'h5A);

    busCycle(16'h1001, 1'b1, 8'hC3, ackCnt, ackCyc, relCnt, rd, ddir, doe, oeStill, oeBack);
    busCycle(16'h1001, 1'b0, 8'h00, ackCnt, ackCyc, relCnt, rd, ddir, doe, oeStill, oeBack);
    checkOutput("busy_rd_stalled", 32'(ackCnt > 4), 32'd1);
    checkOutput("busy_rd_data", 32'(rd), 32'hC3);
    repeat (60) @(negedge CPLDCLK);

    missCycle("miss_slot", 16'h1100, 6'h2D, 1'b0);
    missCycle("miss_am39", 16'h1000, 6'h39, 1'b0);
    missCycle("miss_iack", 16'h1000, 6'h2D, 1'b1);
    missCycle("miss_lowaddr", 16'h1004, 6'h2D, 1'b0);
    missCycle("miss_prefix", 16'h3000, 6'h2D, 1'b0);

    busCycle(16'h1000, 1'b0, 8'h00, ackCnt, ackCyc, relCnt, rd, ddir, doe, oeStill, oeBack);
    checkOutput("am29_ready_rd", 32'(rd), 32'hCD);

    busCycle(16'h1000, 1'b1, 8'h00, ackCnt, ackCyc, relCnt, rd, ddir, doe, oeStill, oeBack);
    checkOutput("csr_clear_m", 32'(M), 32'd0);
    INIT = 1'b0;
    applyStimulus(16'h1000, 6'h29, GA_SLOT16, 1'b0, 8'h00, 1'b0);
    waitAck(200, ackCnt, acked, oeLow);
    checkOutput("rst_ack_reached", 32'(acked), 32'd1);
    XRESET = 1'b0;
    #1;
    checkOutput("rst_ack_dtack", 32'(vme.XDTACK), 32'd1);
    checkOutput("rst_ack_dtackoe", 32'(vme.XDTACKOE), 32'd1);
    checkOutput("rst_ack_xdoe", 32'(vme.XDOE), 32'd0);
    vme.XDS = 2'b11;
    vme.XAS = 1'b1;
    repeat (2) @(negedge CPLDCLK);
    XRESET = 1'b1;
    repeat (3) @(negedge CPLDCLK);
    busCycle(16'h1000, 1'b0, 8'h00, ackCnt, ackCyc, relCnt, rd, ddir, doe, oeStill, oeBack);
    checkOutput("rst_csr_rd", 32'(rd), 32'h8D);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
